mix_sequencer: RTL and testbench
================================

// Module: mix_sequencer
// PURPOSE
//  Slot sequencer for the voice/oscillator volume mixer in the synth engine. On each audio sample tick it
//  walks every (voice, osc, env) slot once at the sCLK_XVXENVS rate. It drives the slot counter xxxx, the
//  voice/osc strobe shift registers sh_voice_reg/sh_osc_reg and the osc-index delay line ox_dly.
//  It then drains the pipeline and reports frame completion, so mixer output latches happen once per sample.
// PARAMETERS
//  VOICES    8   voices per frame
//  V_OSC     4   oscillators per voice
//  O_ENVS    2   envelopes per oscillator
//  V_WIDTH/O_WIDTH/OE_WIDTH/E_WIDTH  derived via utils::clogb2; E_WIDTH=O_WIDTH+OE_WIDTH
//  V_ENVS    V_OSC*O_ENVS; slots per voice
//  x_offset  V_OSC*VOICES-2; top index of ox_dly
//  DRAIN     V_OSC+3; idle slots after the last slot so sh_voice_reg fully flushes
// PORTS
//  sCLK_XVXENVS  in   1                  slot clock (only clock)
//  reset         in   1                  synchronous, active-high
//  sample_tick   in   1                  1-cycle pulse at sample rate; starts a frame
//  xxxx          out  V_WIDTH+E_WIDTH    current slot {voice,osc,env}
//  ox_dly        out  O_WIDTH x[x_offset:0]  ox_dly[k] = osc index k cycles ago (ox_dly[0]=current)
//  sh_voice_reg  out  V_OSC+3            voice-start strobe, delayed 0..V_OSC+2 cycles
//  sh_osc_reg    out  V_ENVS+1           osc-start strobe, delayed 0..V_ENVS cycles
//  busy          out  1                  high in RUN and DRAIN
//  frame_done    out  1                  1-cycle pulse at end of DRAIN
//  overrun       out  1                  sticky: sample_tick arrived while busy
// BEHAVIOUR
//  - Reset: state IDLE; xxxx=0; all ox_dly=0; sh_voice_reg=0; sh_osc_reg=0; busy=0; frame_done=0; overrun=0.
//    Reset mid-frame aborts the frame immediately; no frame_done is issued for it.
//  - FSM IDLE -> RUN on sample_tick (xxxx=0 in the first RUN cycle, i.e. 1 cycle after the tick).
//  - RUN: xxxx increments by 1 each cycle. After xxxx=VOICES*V_ENVS-1 (63 at defaults): -> DRAIN, xxxx wraps to 0.
//  - DRAIN: counts DRAIN cycles with xxxx held at 0; then frame_done=1 for 1 cycle; -> IDLE.
//  - Strobe bit 0 sources, computed from xxxx, valid only in RUN:
//      sh_voice_reg[0] = 1 when env+osc field == 0 (voice start).
//      sh_osc_reg[0]   = 1 when env field == 0 (osc start).
//    Every cycle, including DRAIN/IDLE: sh_*[i] <= sh_*[i-1]. Bit 0 is 0 outside RUN.
//  - ox_dly[0] = osc field of xxxx. Every cycle ox_dly[k] <= ox_dly[k-1]. Value is 0 outside RUN.
//  - sample_tick while busy: ignored and overrun <= 1 (cleared only by reset). A tick coincident with
//    frame_done is also an overrun. A tick in IDLE exactly at cycle of reset deassert is accepted.
//  - The mixer latch slot xxxx==(VOICES-1)*V_ENVS occurs exactly once per frame; clear slot +1 follows next cycle.
//  - Frame length = 1 + VOICES*V_ENVS + DRAIN cycles (tick to frame_done inclusive); the tick period must exceed this.
// STRUCTURE
//  - Shared package synth_pkg: slot_t (V_WIDTH+E_WIDTH), osc_idx_t, seq_state_e {IDLE,RUN,DRAIN},
//    and localparams SLOTS_PER_FRAME = VOICES*V_ENVS and DRAIN.
//  - One sub-module: strobe_delay_line (parameterized width/depth shift register). Instantiated for
//    sh_voice_reg, sh_osc_reg, and per-bit ox_dly.
//  - FSM + counters stay in top; all outputs registered.
// TESTING
//  1 reset=1 for 3 cycles, random sample_tick -> all outputs 0; state IDLE.
//  2 Single tick (defaults) -> xxxx 0..63 on cycles 1..64; sh_voice_reg[0] high at xxxx=0,8,..,56;
//    sh_osc_reg[0] at every even xxxx; frame_done at cycle 72; busy high cycles 1..72.
//  3 During frame -> sh_voice_reg[2] high exactly 2 cycles after each voice start (8 per frame);
//    ox_dly[1] equals the previous cycle's osc field.
//  4 Second tick at cycle 30 of a frame -> overrun=1 and stays 1; the frame still completes
//    with a single frame_done at cycle 72.
//  5 reset asserted at xxxx=20 -> next cycle all outputs 0; no frame_done. A new tick runs a clean frame.
//  6 VOICES=2, V_OSC=2, O_ENVS=1 -> xxxx 0..3, DRAIN=5, frame_done at cycle 10.

Source files
------------

// File: rtl/mix_sequencer_pkg.sv
// Shared types, default geometry and width helpers for the voice/osc mixer slot sequencer.
package mix_sequencer_pkg;

    localparam int unsigned DEF_VOICES = 8;
    localparam int unsigned DEF_V_OSC  = 4;
    localparam int unsigned DEF_O_ENVS = 2;

    // Field width of a power-of-two count; a single-entry field occupies no slot bits.
    function automatic int unsigned clogb2(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Storage width for an index vector that must exist even for a single-entry count.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned V_WIDTH         = clogb2(DEF_VOICES);
    localparam int unsigned O_WIDTH         = clogb2(DEF_V_OSC);
    localparam int unsigned OE_WIDTH        = clogb2(DEF_O_ENVS);
    localparam int unsigned E_WIDTH         = O_WIDTH + OE_WIDTH;
    localparam int unsigned V_ENVS          = DEF_V_OSC * DEF_O_ENVS;
    localparam int unsigned SLOTS_PER_FRAME = DEF_VOICES * V_ENVS;
    localparam int unsigned DRAIN           = DEF_V_OSC + 3;

    typedef logic [V_WIDTH+E_WIDTH-1:0] slot_t;
    typedef logic [O_WIDTH-1:0]         osc_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mix_sequencer_if.sv
// Sequencer-to-mixer bundle: frame trigger in, slot index, strobes and status out.
interface mix_sequencer_if
    import mix_sequencer_pkg::*;
#(
    parameter int unsigned VOICES = DEF_VOICES,
    parameter int unsigned V_OSC  = DEF_V_OSC,
    parameter int unsigned O_ENVS = DEF_O_ENVS
);
    localparam int unsigned SLOT_W   = clogb2(VOICES) + clogb2(V_OSC) + clogb2(O_ENVS);
    localparam int unsigned OSC_W    = width_of(V_OSC);
    localparam int unsigned X_OFFSET = V_OSC * VOICES - 2;
    localparam int unsigned V_ENVS   = V_OSC * O_ENVS;

    logic              sample_tick;
    logic [SLOT_W-1:0] xxxx;
    logic [OSC_W-1:0]  ox_dly [X_OFFSET:0];
    logic [V_OSC+2:0]  sh_voice_reg;
    logic [V_ENVS:0]   sh_osc_reg;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    modport master (
        input  sample_tick,
        output xxxx, ox_dly, sh_voice_reg, sh_osc_reg, busy, frame_done, overrun
    );

    modport slave (
        output sample_tick,
        input  xxxx, ox_dly, sh_voice_reg, sh_osc_reg, busy, frame_done, overrun
    );

endinterface

// File: rtl/mix_sequencer_strobe_delay_line.sv
// Resettable shift register: q[0] is din registered, q[k] is din delayed k+1 cycles.
module strobe_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             din,
    output logic [DEPTH-1:0][WIDTH-1:0]  q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= {q[DEPTH-2:0], din};
        end
    end

endmodule

// File: rtl/mix_sequencer.sv
// Walks every (voice, osc, env) slot once per sample tick, then drains the strobe pipeline
// and pulses frame_done so mixer output latches happen exactly once per sample.
module mix_sequencer
    import mix_sequencer_pkg::*;
#(
    parameter int unsigned VOICES = DEF_VOICES,
    parameter int unsigned V_OSC  = DEF_V_OSC,
    parameter int unsigned O_ENVS = DEF_O_ENVS
) (
    input  logic            sCLK_XVXENVS,
    input  logic            reset,
    mix_sequencer_if.master bus
);

    localparam int unsigned V_ENVS       = V_OSC * O_ENVS;
    localparam int unsigned SLOTS        = VOICES * V_ENVS;
    localparam int unsigned OE_W         = clogb2(O_ENVS);
    localparam int unsigned SLOT_W       = clogb2(VOICES) + clogb2(V_OSC) + OE_W;
    localparam int unsigned OSC_W        = width_of(V_OSC);
    localparam int unsigned X_OFFSET     = V_OSC * VOICES - 2;
    localparam int unsigned OX_DEPTH     = X_OFFSET + 1;
    localparam int unsigned SHV_DEPTH    = V_OSC + 3;
    localparam int unsigned SHO_DEPTH    = V_ENVS + 1;
    localparam int unsigned DRAIN_CYCLES = V_OSC + 3;
    localparam int unsigned CNT_W        = $clog2(DRAIN_CYCLES + 1);

    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] VOICE_MASK = SLOT_W'(V_ENVS - 1);
    localparam logic [SLOT_W-1:0] ENV_MASK   = SLOT_W'(O_ENVS - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]  DONE_PRE   = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              run_d;
    logic              voice_start_d;
    logic              osc_start_d;
    logic [OSC_W-1:0]  osc_d;

    // State and status registers.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next state; strobe sources are taken from the next slot so every tap lines up with xxxx.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q | (bus.sample_tick & busy_q);

        unique case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                if (bus.sample_tick) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_DRAIN;
                    slot_d  = '0;
                    drain_d = '0;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            ST_DRAIN: begin
                slot_d = '0;
                if (drain_q == DONE_PRE) begin
                    done_d = 1'b1;
                end
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase

        busy_d        = (state_d != ST_IDLE);
        run_d         = (state_d == ST_RUN);
        voice_start_d = run_d && ((slot_d & VOICE_MASK) == '0);
        osc_start_d   = run_d && ((slot_d & ENV_MASK) == '0);
        osc_d         = run_d ? OSC_W'(slot_d >> OE_W) : '0;
    end

    logic [SHV_DEPTH-1:0][0:0] shv_q;
    logic [SHO_DEPTH-1:0][0:0] sho_q;
    logic [OX_DEPTH-1:0][0:0]  ox_bits [OSC_W];
    logic [OSC_W-1:0]          ox_tap  [X_OFFSET:0];

    strobe_delay_line #(.WIDTH(1), .DEPTH(SHV_DEPTH)) u_sh_voice (
        .clk   (sCLK_XVXENVS),
        .reset (reset),
        .din   (voice_start_d),
        .q     (shv_q)
    );

    strobe_delay_line #(.WIDTH(1), .DEPTH(SHO_DEPTH)) u_sh_osc (
        .clk   (sCLK_XVXENVS),
        .reset (reset),
        .din   (osc_start_d),
        .q     (sho_q)
    );

    // One delay line per osc-index bit, regathered into per-tap words below.
    for (genvar b = 0; b < int'(OSC_W); b++) begin : g_ox
        strobe_delay_line #(.WIDTH(1), .DEPTH(OX_DEPTH)) u_ox (
            .clk   (sCLK_XVXENVS),
            .reset (reset),
            .din   (osc_d[b]),
            .q     (ox_bits[b])
        );
    end

    always_comb begin
        ox_tap = '{default: '0};
        for (int k = 0; k <= int'(X_OFFSET); k++) begin
            for (int b = 0; b < int'(OSC_W); b++) begin
                ox_tap[k][b] = ox_bits[b][k][0];
            end
        end
    end

    assign bus.xxxx         = slot_q;
    assign bus.ox_dly       = ox_tap;
    assign bus.sh_voice_reg = shv_q;
    assign bus.sh_osc_reg   = sho_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = done_q;
    assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer: default geometry plus a 2x2x1 instance.
module tb_mix_sequencer;
    import mix_sequencer_pkg::*;

    localparam int FRAME_END = int'(SLOTS_PER_FRAME + DRAIN + 1);

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mix_sequencer_if bus0 ();
    mix_sequencer_if #(.VOICES(2), .V_OSC(2), .O_ENVS(1)) bus1 ();

    mix_sequencer dut0 (
        .sCLK_XVXENVS (clk),
        .reset        (reset),
        .bus          (bus0)
    );

    mix_sequencer #(.VOICES(2), .V_OSC(2), .O_ENVS(1)) dut1 (
        .sCLK_XVXENVS (clk),
        .reset        (reset),
        .bus          (bus1)
    );

    // Default-geometry model: slot s runs on cycle s+1 after the tick.
    function automatic int slot_at(input int c);
        return (c >= 1 && c <= int'(SLOTS_PER_FRAME)) ? c - 1 : -1;
    endfunction

    function automatic logic vstart_at(input int c);
        int s;
        s = slot_at(c);
        return (s >= 0) && (s % 8 == 0);
    endfunction

    function automatic logic ostart_at(input int c);
        int s;
        s = slot_at(c);
        return (s >= 0) && (s % 2 == 0);
    endfunction

    function automatic osc_idx_t osc_at(input int c);
        int s;
        s = slot_at(c);
        return (s >= 0) ? osc_idx_t'((s / 2) % 4) : osc_idx_t'(0);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus0.sample_tick = 1'b0;
        bus1.sample_tick = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus0.sample_tick = 1'($urandom_range(0, 1));
            bus1.sample_tick = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus0.sample_tick = 1'b0;
        bus1.sample_tick = 1'b0;
        checks++; if (bus0.xxxx !== slot_t'(0)) begin errors++; $display("FAIL reset_xxxx got=%0h exp=0", bus0.xxxx); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
        checks++; if (bus0.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", bus0.frame_done); end
        checks++; if (bus0.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus0.overrun); end
        checks++; if (bus0.sh_voice_reg !== 7'd0) begin errors++; $display("FAIL reset_sh_voice got=%0h exp=0", bus0.sh_voice_reg); end
        checks++; if (bus0.sh_osc_reg !== 9'd0) begin errors++; $display("FAIL reset_sh_osc got=%0h exp=0", bus0.sh_osc_reg); end
        for (int k = 0; k <= 30; k++) begin
            checks++; if (bus0.ox_dly[k] !== osc_idx_t'(0)) begin errors++; $display("FAIL reset_ox_dly k=%0d got=%0h exp=0", k, bus0.ox_dly[k]); end
        end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_small got=%b exp=0", bus1.busy); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", bus0.busy); end
        checks++; if (bus0.xxxx !== slot_t'(0)) begin errors++; $display("FAIL post_reset_xxxx got=%0h exp=0", bus0.xxxx); end
    endtask

    task automatic test_single_frame();
        int fd;
        fd = 0;
        idle(2);
        bus0.sample_tick = 1'b1;
        for (int c = 1; c <= FRAME_END + 3; c++) begin
            @(negedge clk);
            bus0.sample_tick = 1'b0;
            if (bus0.frame_done === 1'b1) fd++;
            checks++; if (bus0.xxxx !== slot_t'(slot_at(c) < 0 ? 0 : slot_at(c))) begin errors++; $display("FAIL frame_xxxx c=%0d got=%0d exp=%0d", c, bus0.xxxx, slot_at(c)); end
            checks++; if (bus0.busy !== 1'(c <= FRAME_END)) begin errors++; $display("FAIL frame_busy c=%0d got=%b", c, bus0.busy); end
            checks++; if (bus0.frame_done !== 1'(c == FRAME_END)) begin errors++; $display("FAIL frame_done c=%0d got=%b", c, bus0.frame_done); end
            checks++; if (bus0.sh_voice_reg[0] !== vstart_at(c)) begin errors++; $display("FAIL frame_sh_voice0 c=%0d got=%b exp=%b", c, bus0.sh_voice_reg[0], vstart_at(c)); end
            checks++; if (bus0.sh_osc_reg[0] !== ostart_at(c)) begin errors++; $display("FAIL frame_sh_osc0 c=%0d got=%b exp=%b", c, bus0.sh_osc_reg[0], ostart_at(c)); end
            checks++; if (bus0.ox_dly[0] !== osc_at(c)) begin errors++; $display("FAIL frame_ox0 c=%0d got=%0d exp=%0d", c, bus0.ox_dly[0], osc_at(c)); end
        end
        checks++; if (fd != 1) begin errors++; $display("FAIL frame_done_count got=%0d exp=1", fd); end
    endtask

    task automatic test_strobe_delay();
        int v2;
        v2 = 0;
        idle(40);
        bus0.sample_tick = 1'b1;
        for (int c = 1; c <= FRAME_END + 3; c++) begin
            @(negedge clk);
            bus0.sample_tick = 1'b0;
            if (bus0.sh_voice_reg[2] === 1'b1) v2++;
            checks++; if (bus0.sh_voice_reg[2] !== vstart_at(c - 2)) begin errors++; $display("FAIL sh_voice2 c=%0d got=%b exp=%b", c, bus0.sh_voice_reg[2], vstart_at(c - 2)); end
            checks++; if (bus0.sh_voice_reg[6] !== vstart_at(c - 6)) begin errors++; $display("FAIL sh_voice6 c=%0d got=%b exp=%b", c, bus0.sh_voice_reg[6], vstart_at(c - 6)); end
            checks++; if (bus0.sh_osc_reg[8] !== ostart_at(c - 8)) begin errors++; $display("FAIL sh_osc8 c=%0d got=%b exp=%b", c, bus0.sh_osc_reg[8], ostart_at(c - 8)); end
            checks++; if (bus0.ox_dly[1] !== osc_at(c - 1)) begin errors++; $display("FAIL ox1 c=%0d got=%0d exp=%0d", c, bus0.ox_dly[1], osc_at(c - 1)); end
            checks++; if (bus0.ox_dly[30] !== osc_at(c - 30)) begin errors++; $display("FAIL ox30 c=%0d got=%0d exp=%0d", c, bus0.ox_dly[30], osc_at(c - 30)); end
        end
        checks++; if (v2 != 8) begin errors++; $display("FAIL sh_voice2_count got=%0d exp=8", v2); end
    endtask

    task automatic test_overrun();
        int fd;
        fd = 0;
        idle(40);
        bus0.sample_tick = 1'b1;
        for (int c = 1; c <= FRAME_END + 3; c++) begin
            @(negedge clk);
            bus0.sample_tick = 1'b0;
            if (bus0.frame_done === 1'b1) fd++;
            checks++; if (bus0.overrun !== 1'(c >= 31)) begin errors++; $display("FAIL overrun c=%0d got=%b", c, bus0.overrun); end
            checks++; if (bus0.xxxx !== slot_t'(slot_at(c) < 0 ? 0 : slot_at(c))) begin errors++; $display("FAIL overrun_xxxx c=%0d got=%0d exp=%0d", c, bus0.xxxx, slot_at(c)); end
            checks++; if (bus0.frame_done !== 1'(c == FRAME_END)) begin errors++; $display("FAIL overrun_frame_done c=%0d got=%b", c, bus0.frame_done); end
            if (c == 30) bus0.sample_tick = 1'b1;
        end
        checks++; if (fd != 1) begin errors++; $display("FAIL overrun_done_count got=%0d exp=1", fd); end
        idle(5);
        checks++; if (bus0.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", bus0.overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int fd;
        fd = 0;
        idle(5);
        bus0.sample_tick = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            bus0.sample_tick = 1'b0;
        end
        checks++; if (bus0.xxxx !== slot_t'(20)) begin errors++; $display("FAIL abort_pre_xxxx got=%0d exp=20", bus0.xxxx); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus0.xxxx !== slot_t'(0)) begin errors++; $display("FAIL abort_xxxx got=%0d exp=0", bus0.xxxx); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus0.busy); end
        checks++; if (bus0.overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got=%b exp=0", bus0.overrun); end
        checks++; if (bus0.sh_voice_reg !== 7'd0) begin errors++; $display("FAIL abort_sh_voice got=%0h exp=0", bus0.sh_voice_reg); end
        checks++; if (bus0.sh_osc_reg !== 9'd0) begin errors++; $display("FAIL abort_sh_osc got=%0h exp=0", bus0.sh_osc_reg); end
        checks++; if (bus0.ox_dly[1] !== osc_idx_t'(0)) begin errors++; $display("FAIL abort_ox1 got=%0d exp=0", bus0.ox_dly[1]); end
        reset = 1'b0;
        bus0.sample_tick = 1'b1;
        for (int c = 1; c <= FRAME_END + 3; c++) begin
            @(negedge clk);
            bus0.sample_tick = 1'b0;
            if (bus0.frame_done === 1'b1) fd++;
            checks++; if (bus0.xxxx !== slot_t'(slot_at(c) < 0 ? 0 : slot_at(c))) begin errors++; $display("FAIL restart_xxxx c=%0d got=%0d exp=%0d", c, bus0.xxxx, slot_at(c)); end
            checks++; if (bus0.frame_done !== 1'(c == FRAME_END)) begin errors++; $display("FAIL restart_frame_done c=%0d got=%b", c, bus0.frame_done); end
            checks++; if (bus0.sh_voice_reg[0] !== vstart_at(c)) begin errors++; $display("FAIL restart_sh_voice0 c=%0d got=%b", c, bus0.sh_voice_reg[0]); end
        end
        checks++; if (fd != 1) begin errors++; $display("FAIL restart_done_count got=%0d exp=1", fd); end
    endtask

    task automatic test_small_config();
        int  s;
        logic exp_busy;
        idle(10);
        bus1.sample_tick = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus1.sample_tick = 1'b0;
            s = (c >= 1 && c <= 4) ? c - 1 : ((c == 12) ? 0 : -1);
            exp_busy = 1'((c <= 10) || (c == 12));
            checks++; if (bus1.xxxx !== 2'(s < 0 ? 0 : s)) begin errors++; $display("FAIL small_xxxx c=%0d got=%0d exp=%0d", c, bus1.xxxx, s); end
            checks++; if (bus1.busy !== exp_busy) begin errors++; $display("FAIL small_busy c=%0d got=%b exp=%b", c, bus1.busy, exp_busy); end
            checks++; if (bus1.frame_done !== 1'(c == 10)) begin errors++; $display("FAIL small_frame_done c=%0d got=%b", c, bus1.frame_done); end
            checks++; if (bus1.overrun !== 1'(c >= 11)) begin errors++; $display("FAIL small_overrun c=%0d got=%b", c, bus1.overrun); end
            checks++; if (bus1.sh_voice_reg[0] !== 1'((s >= 0) && (s % 2 == 0))) begin errors++; $display("FAIL small_sh_voice0 c=%0d got=%b", c, bus1.sh_voice_reg[0]); end
            checks++; if (bus1.sh_osc_reg[0] !== 1'(s >= 0)) begin errors++; $display("FAIL small_sh_osc0 c=%0d got=%b", c, bus1.sh_osc_reg[0]); end
            checks++; if (bus1.ox_dly[0] !== 1'(s >= 0 ? s % 2 : 0)) begin errors++; $display("FAIL small_ox0 c=%0d got=%0d", c, bus1.ox_dly[0]); end
            // Tick on the frame_done cycle is an overrun; the following idle-cycle tick is accepted.
            if (c == 10 || c == 11) bus1.sample_tick = 1'b1;
        end
        idle(15);
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL small_final_busy got=%b exp=0", bus1.busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus0.sample_tick = 1'b0;
        bus1.sample_tick = 1'b0;
        test_reset();
        test_single_frame();
        test_strobe_delay();
        test_overrun();
        test_reset_mid_frame();
        test_small_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
